seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential signed divider: 33-bit two's-complement operands, restoring
// division over 33 cycles on 34-bit magnitudes, truncating toward zero with
// the remainder taking the dividend's sign. Divide-by-zero and the single
// overflow case (-2^32 / -1) are resolved early without iterating.
module seq_divider (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [32:0] opA,
  input  logic [32:0] opB,
  output logic        ready,
  output logic [32:0] Qval,
  output logic [32:0] Rval,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } state_t;

  localparam logic [32:0] MIN_A   = 33'h1_0000_0000;  // -2^32
  localparam logic [32:0] MINUS_1 = 33'h1_FFFF_FFFF;
  localparam logic [5:0]  LAST    = 6'd32;            // 33 steps: 0..32

  state_t      r_state;
  state_t      w_next;

  logic [32:0] r_a;        // operands captured at acceptance
  logic [32:0] r_b;
  logic [33:0] r_rem;      // partial remainder
  logic [32:0] r_quo;      // dividend bits shifting out, quotient bits shifting in
  logic [33:0] r_dvs;      // |divisor|
  logic [5:0]  r_cnt;
  logic        r_sign_q;
  logic        r_sign_r;
  logic [32:0] r_q_out;
  logic [32:0] r_r_out;
  logic        r_dbz;

  logic        w_b_zero;
  logic        w_ovf;
  logic        w_special;
  logic [33:0] w_a_ext;
  logic [33:0] w_b_ext;
  logic [33:0] w_a_mag;
  logic [33:0] w_b_mag;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_last;

  // 34-bit magnitudes so that |-2^32| is exact.
  assign w_a_ext   = {r_a[32], r_a};
  assign w_b_ext   = {r_b[32], r_b};
  assign w_a_mag   = r_a[32] ? (34'd0 - w_a_ext) : w_a_ext;
  assign w_b_mag   = r_b[32] ? (34'd0 - w_b_ext) : w_b_ext;

  assign w_b_zero  = (r_b == 33'd0);
  assign w_ovf     = (r_a == MIN_A) && (r_b == MINUS_1);
  assign w_special = w_b_zero || w_ovf;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  // The shifted value is below 2^33 and the divisor at most 2^32, so bit 33
  // of the 34-bit difference is a reliable sign.
  assign w_shift   = {r_rem[32:0], r_quo[32]};
  assign w_diff    = w_shift - r_dvs;
  assign w_last    = (r_cnt == LAST);

  assign ready       = (r_state == IDLE);
  assign Qval        = r_q_out;
  assign Rval        = r_r_out;
  assign div_by_zero = r_dbz;

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE:    if (Run)    w_next = SETUP;
      SETUP:   w_next = w_special ? IDLE : ITER;
      ITER:    if (w_last) w_next = FIXUP;
      FIXUP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over Run.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Datapath: operand capture, setup, iteration and sign fix-up.
  always_ff @(posedge Clk) begin
    // NOTE: only the counter and visible results are reset; working registers
    // are always loaded in SETUP before use, so they need no reset.
    if (Reset) begin
      r_cnt   <= 6'd0;
      r_q_out <= 33'd0;
      r_r_out <= 33'd0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Run) begin
            r_a <= opA;
            r_b <= opB;
          end
        end
        SETUP: begin
          r_rem    <= 34'd0;
          r_quo    <= w_a_mag[32:0];
          r_dvs    <= w_b_mag;
          r_sign_q <= r_a[32] ^ r_b[32];
          r_sign_r <= r_a[32];
          r_cnt    <= 6'd0;
          if (w_b_zero) begin
            r_q_out <= MINUS_1;
            r_r_out <= r_a;
            r_dbz   <= 1'b1;
          end else if (w_ovf) begin
            r_q_out <= r_a;
            r_r_out <= 33'd0;
            r_dbz   <= 1'b0;
          end
        end
        ITER: begin
          r_rem <= w_diff[33] ? w_shift : w_diff;
          r_quo <= {r_quo[31:0], ~w_diff[33]};
          r_cnt <= r_cnt + 6'd1;
        end
        FIXUP: begin
          r_q_out <= r_sign_q ? (33'd0 - r_quo) : r_quo;
          r_r_out <= r_sign_r ? (33'd0 - r_rem[32:0]) : r_rem[32:0];
          r_dbz   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider: hand-computed quotient/remainder
// vectors, latency, special cases, mid-operation reset and held Run.
module tb_seq_divider;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic [32:0] opA;
  logic [32:0] opB;
  logic        ready;
  logic [32:0] Qval;
  logic [32:0] Rval;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Run        (Run),
    .opA        (opA),
    .opB        (opB),
    .ready      (ready),
    .Qval       (Qval),
    .Rval       (Rval),
    .div_by_zero(div_by_zero)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Present operands with a one-cycle Run pulse; returns just after E0.
  task automatic start(input logic [32:0] a, input logic [32:0] b);
    opA = a;
    opB = b;
    Run = 1'b1;
    edges(1);
    Run = 1'b0;
  endtask

  // Full-length operation: ready low on E0..E0+34, results held until E0+35.
  task automatic normal_op(input string tag, input logic [32:0] a, input logic [32:0] b,
                           input logic [32:0] q, input logic [32:0] r);
    logic [32:0] prev_q;
    logic        busy_ok;
    prev_q  = Qval;
    start(a, b);
    busy_ok = (ready === 1'b0);
    for (int i = 1; i <= 34; i++) begin
      edges(1);
      if (ready !== 1'b0) busy_ok = 1'b0;
    end
    check({tag, "_busy"}, {32'd0, busy_ok}, 33'd1);
    check({tag, "_hold_q"}, Qval, prev_q);
    edges(1);
    check({tag, "_ready"}, {32'd0, ready}, 33'd1);
    check({tag, "_q"}, Qval, q);
    check({tag, "_r"}, Rval, r);
    check({tag, "_dbz"}, {32'd0, div_by_zero}, 33'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    opA   = 33'd0;
    opB   = 33'd0;
    edges(2);
    check("rst_ready", {32'd0, ready}, 33'd1);
    check("rst_q", Qval, 33'd0);
    check("rst_r", Rval, 33'd0);
    check("rst_dbz", {32'd0, div_by_zero}, 33'd0);
    Reset = 1'b0;
    edges(1);

    normal_op("pos", 33'd500, 33'd7, 33'd71, 33'd3);
    normal_op("neg_a", 33'h1_FFFF_FE0C, 33'd7, 33'h1_FFFF_FFB9, 33'h1_FFFF_FFFD);
    normal_op("zero_a", 33'd0, 33'd500, 33'd0, 33'd0);

    // Divide by zero resolves two edges after acceptance.
    start(33'd500, 33'd0);
    edges(1);
    edges(1);
    check("dz_ready", {32'd0, ready}, 33'd1);
    check("dz_q", Qval, 33'h1_FFFF_FFFF);
    check("dz_r", Rval, 33'd500);
    check("dz_flag", {32'd0, div_by_zero}, 33'd1);

    // Negative divisor; also clears div_by_zero: 100 / -7 = -14 rem 2.
    normal_op("neg_b", 33'd100, 33'h1_FFFF_FFF9, 33'h1_FFFF_FFF2, 33'd2);

    // Full-scale negative dividend exercises the 34-bit magnitude path.
    normal_op("min_by_1", 33'h1_0000_0000, 33'd1, 33'h1_0000_0000, 33'd0);

    // Overflow: -2^32 / -1.
    start(33'h1_0000_0000, 33'h1_FFFF_FFFF);
    edges(2);
    check("ovf_ready", {32'd0, ready}, 33'd1);
    check("ovf_q", Qval, 33'h1_0000_0000);
    check("ovf_r", Rval, 33'd0);
    check("ovf_dbz", {32'd0, div_by_zero}, 33'd0);

    // Reset at E0+10 discards the operation.
    start(33'd500, 33'd7);
    edges(9);
    check("mid_busy", {32'd0, ready}, 33'd0);
    Reset = 1'b1;
    Run   = 1'b1;  // reset wins over Run on the same edge
    edges(1);
    Reset = 1'b0;
    Run   = 1'b0;
    check("mid_rst_ready", {32'd0, ready}, 33'd1);
    check("mid_rst_q", Qval, 33'd0);
    check("mid_rst_r", Rval, 33'd0);
    normal_op("after_rst", 33'd100, 33'd9, 33'd11, 33'd1);

    // Run held high: operand change mid-flight ignored, next op accepted on
    // the first ready edge (E0+36) with the operands applied at that time.
    opA = 33'd500;
    opB = 33'd7;
    Run = 1'b1;
    edges(1);                      // E0
    edges(4);                      // E0+4
    opA = 33'd1000;
    edges(31);                     // E0+35
    check("held1_ready", {32'd0, ready}, 33'd1);
    check("held1_q", Qval, 33'd71);
    check("held1_r", Rval, 33'd3);
    edges(1);                      // E0+36: second acceptance
    check("held2_accept", {32'd0, ready}, 33'd0);
    edges(34);                     // E0+70
    check("held2_busy", {32'd0, ready}, 33'd0);
    check("held2_hold_q", Qval, 33'd71);
    Run = 1'b0;
    edges(1);                      // E0+71
    check("held2_ready", {32'd0, ready}, 33'd1);
    check("held2_q", Qval, 33'd142);
    check("held2_r", Rval, 33'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
